// File: rtl/ttt_move_gen_pkg.sv
// Shared types and lookup tables for the tic-tac-toe computer-move generator.
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    typedef logic [1:0] cell_t;
    typedef logic [3:0] cellIdx_t;

    localparam cell_t CELL_EMPTY  = 2'b00;
    localparam cell_t CELL_PLAYER = 2'b01;
    localparam cell_t CELL_COMP   = 2'b10;

    // Rows, columns, then the two diagonals; scan order sets move priority.
    localparam cellIdx_t LINES [0:7][0:2] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    localparam cellIdx_t CORNERS [0:3] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam cellIdx_t EDGES   [0:3] = '{4'd1, 4'd3, 4'd5, 4'd7};

    typedef enum logic [2:0] {
        IDLE, WIN, BLOCK, CENTER, CORNER, EDGE, ISSUE
    } state_t;

endpackage

// File: rtl/ttt_move_gen_if.sv
// Request/board/strobe bundle between the game controller and the move generator.
interface ttt_move_gen_if;
    import ttt_pkg::*;

    logic     req;
    logic     game_over;
    cell_t    pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    cellIdx_t computer_position;
    logic     pc;
    logic     busy;
    logic     no_move;

    modport master (
        output req, game_over, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  computer_position, pc, busy, no_move
    );

    modport slave (
        input  req, game_over, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output computer_position, pc, busy, no_move
    );

endinterface

// File: rtl/ttt_line_eval.sv
// Combinational check of one board line: two cells of the target mark plus one empty cell.
module ttt_line_eval
    import ttt_pkg::*;
(
    input  cell_t    cellA_i,
    input  cell_t    cellB_i,
    input  cell_t    cellC_i,
    input  cellIdx_t idxA_i,
    input  cellIdx_t idxB_i,
    input  cellIdx_t idxC_i,
    input  cell_t    mark_i,
    output logic     hit_o,
    output cellIdx_t emptyIdx_o
);

    logic [1:0] markCnt;
    logic [1:0] emptyCnt;

    // Only 2'b00 counts as empty, so a corrupt 2'b11 cell blocks the line.
    always_comb begin
        markCnt  = 2'(cellA_i == mark_i) + 2'(cellB_i == mark_i) + 2'(cellC_i == mark_i);
        emptyCnt = 2'(cellA_i == CELL_EMPTY) + 2'(cellB_i == CELL_EMPTY) + 2'(cellC_i == CELL_EMPTY);
        emptyIdx_o = idxA_i;
        if (cellB_i == CELL_EMPTY) emptyIdx_o = idxB_i;
        if (cellC_i == CELL_EMPTY) emptyIdx_o = idxC_i;
        hit_o = (markCnt == 2'd2) && (emptyCnt == 2'd1);
    end

endmodule

// File: rtl/ttt_move_gen.sv
// Computer-move generator: snapshots the board on request and scans win > block > centre >
// corner > edge, one line or cell per clock, then strobes the chosen cell into tic_tac_toe.
module ttt_move_gen
    import ttt_pkg::*;
#(
    parameter int PC_HOLD = 2
)(
    input  logic          clock,
    input  logic          reset_n,
    ttt_move_gen_if.slave bus
);

    localparam int HW = (PC_HOLD > 1) ? $clog2(PC_HOLD) : 1;

    state_t   state_q;
    cell_t    snap_q [NUM_CELLS];
    logic [2:0] idx_q;
    logic [HW-1:0] hold_q;
    cellIdx_t pos_q;
    logic     pc_q;
    logic     busy_q;
    logic     noMove_q;

    cellIdx_t lineIdx [3];
    cell_t    mark;
    logic     evalHit;
    cellIdx_t evalCell;
    logic     scanHit;
    cellIdx_t scanCell;

    always_comb begin
        for (int j = 0; j < 3; j++) lineIdx[j] = LINES[idx_q][j];
        mark = (state_q == WIN) ? CELL_COMP : CELL_PLAYER;
    end

    ttt_line_eval u_line_eval (
        .cellA_i    (snap_q[lineIdx[0]]),
        .cellB_i    (snap_q[lineIdx[1]]),
        .cellC_i    (snap_q[lineIdx[2]]),
        .idxA_i     (lineIdx[0]),
        .idxB_i     (lineIdx[1]),
        .idxC_i     (lineIdx[2]),
        .mark_i     (mark),
        .hit_o      (evalHit),
        .emptyIdx_o (evalCell)
    );

    always_comb begin
        scanHit  = 1'b0;
        scanCell = 4'd0;
        case (state_q)
            WIN, BLOCK: begin
                scanHit  = evalHit;
                scanCell = evalCell;
            end
            CENTER: begin
                scanCell = 4'd4;
                scanHit  = (snap_q[4] == CELL_EMPTY);
            end
            CORNER: begin
                scanCell = CORNERS[idx_q[1:0]];
                scanHit  = (snap_q[scanCell] == CELL_EMPTY);
            end
            EDGE: begin
                scanCell = EDGES[idx_q[1:0]];
                scanHit  = (snap_q[scanCell] == CELL_EMPTY);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            snap_q   <= '{default: CELL_EMPTY};
            idx_q    <= 3'd0;
            hold_q   <= '0;
            pos_q    <= 4'd0;
            pc_q     <= 1'b0;
            busy_q   <= 1'b0;
            noMove_q <= 1'b0;
        end else begin
            noMove_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req && !bus.game_over) begin
                        snap_q <= '{bus.pos1, bus.pos2, bus.pos3, bus.pos4, bus.pos5,
                                    bus.pos6, bus.pos7, bus.pos8, bus.pos9};
                        idx_q   <= 3'd0;
                        state_q <= WIN;
                        busy_q  <= 1'b1;
                    end
                end
                WIN, BLOCK, CENTER, CORNER, EDGE: begin
                    // Game ending mid-scan abandons the move silently.
                    if (bus.game_over) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (scanHit) begin
                        pos_q   <= scanCell;
                        pc_q    <= 1'b1;
                        hold_q  <= HW'(PC_HOLD - 1);
                        state_q <= ISSUE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        case (state_q)
                            WIN:    if (idx_q == 3'd7) begin idx_q <= 3'd0; state_q <= BLOCK; end
                            BLOCK:  if (idx_q == 3'd7) begin idx_q <= 3'd0; state_q <= CENTER; end
                            CENTER: begin idx_q <= 3'd0; state_q <= CORNER; end
                            CORNER: if (idx_q == 3'd3) begin idx_q <= 3'd0; state_q <= EDGE; end
                            default: if (idx_q == 3'd3) begin
                                idx_q    <= 3'd0;
                                noMove_q <= 1'b1;
                                busy_q   <= 1'b0;
                                state_q  <= IDLE;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (hold_q == '0) begin
                        pc_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.computer_position = pos_q;
    assign bus.pc                = pc_q;
    assign bus.busy              = busy_q;
    assign bus.no_move           = noMove_q;

endmodule

// File: tb/tb_ttt_move_gen.sv
// Scoreboard bench for ttt_move_gen: expected moves are queued at request time and
// popped when pc or no_move appears, with latency measured in clock edges.
module tb_ttt_move_gen;
    import ttt_pkg::*;

    typedef struct {
        bit       isMove;
        logic [3:0] pos;
        int       lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    ttt_move_gen_if bus();

    ttt_move_gen #(.PC_HOLD(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [17:0] mkBoard(input logic [8:0] xMask, input logic [8:0] oMask);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (xMask[i]) b[2*i +: 2] = CELL_PLAYER;
            if (oMask[i]) b[2*i +: 2] = CELL_COMP;
        end
        return b;
    endfunction

    task automatic applyStimulus(input logic [17:0] b);
        bus.pos1 = b[1:0];   bus.pos2 = b[3:2];   bus.pos3 = b[5:4];
        bus.pos4 = b[7:6];   bus.pos5 = b[9:8];   bus.pos6 = b[11:10];
        bus.pos7 = b[13:12]; bus.pos8 = b[15:14]; bus.pos9 = b[17:16];
    endtask

    task automatic issueReq(output int k);
        @(negedge clock);
        bus.req = 1'b1;
        @(posedge clock);
        #1;
        k = cyc;
        @(negedge clock);
        bus.req = 1'b0;
    endtask

    task automatic waitEvent(input int k, input int maxCyc, output bit seen, output bit isMove,
                             output logic [3:0] pos, output int lat);
        bit done;
        seen = 0; isMove = 0; pos = '0; lat = -1; done = 0;
        for (int i = 0; i < maxCyc && !done; i++) begin
            @(negedge clock);
            if (bus.pc || bus.no_move) begin
                seen = 1; isMove = bus.pc; pos = bus.computer_position; lat = cyc - k;
                done = 1;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.pc !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc got %b want 0", bus.pc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.no_move !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_move got %b want 0", bus.no_move); end
        checks++; if (bus.computer_position !== 4'd0) begin errors++; $display("[TB] FAIL reset_pos got %0d want 0", bus.computer_position); end
    endtask

    task automatic test_center();
        int k, lat; bit seen, isMove; logic [3:0] pos; exp_t e;
        applyStimulus(18'd0);
        sbQ.push_back('{isMove: 1'b1, pos: 4'd4, lat: 17});
        issueReq(k);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL center_busy got %b want 1", bus.busy); end
        waitEvent(k, 40, seen, isMove, pos, lat);
        e = sbQ.pop_front();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL center_timeout got none want move"); end
        else begin
            checks++; if (isMove !== e.isMove) begin errors++; $display("[TB] FAIL center_kind got %b want %b", isMove, e.isMove); end
            checks++; if (pos !== e.pos) begin errors++; $display("[TB] FAIL center_pos got %0d want %0d", pos, e.pos); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL center_lat got %0d want %0d", lat, e.lat); end
            @(negedge clock);
            checks++; if (bus.pc !== 1'b1 || bus.computer_position !== e.pos) begin errors++; $display("[TB] FAIL center_hold got pc=%b pos=%0d want pc=1 pos=%0d", bus.pc, bus.computer_position, e.pos); end
            @(negedge clock);
            checks++; if (bus.pc !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL center_end got pc=%b busy=%b want 0 0", bus.pc, bus.busy); end
            checks++; if (bus.computer_position !== e.pos) begin errors++; $display("[TB] FAIL center_pos_keep got %0d want %0d", bus.computer_position, e.pos); end
        end
    endtask

    task automatic test_block_and_drop();
        int k, lat; bit seen, isMove; logic [3:0] pos; exp_t e;
        applyStimulus(mkBoard(9'b000000011, 9'b000010000));
        sbQ.push_back('{isMove: 1'b1, pos: 4'd2, lat: 9});
        issueReq(k);
        repeat (2) @(negedge clock);
        bus.req = 1'b1;
        @(negedge clock);
        bus.req = 1'b0;
        waitEvent(k, 40, seen, isMove, pos, lat);
        e = sbQ.pop_front();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL block_timeout got none want move"); end
        else begin
            checks++; if (isMove !== e.isMove) begin errors++; $display("[TB] FAIL block_kind got %b want %b", isMove, e.isMove); end
            checks++; if (pos !== e.pos) begin errors++; $display("[TB] FAIL block_pos got %0d want %0d", pos, e.pos); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL block_lat got %0d want %0d", lat, e.lat); end
        end
        repeat (2) @(negedge clock);
        waitEvent(cyc, 30, seen, isMove, pos, lat);
        checks++; if (seen) begin errors++; $display("[TB] FAIL dropped_req got event pc=%b want none", isMove); end
    endtask

    task automatic test_win_priority();
        int k, lat; bit seen, isMove; logic [3:0] pos; exp_t e;
        applyStimulus(mkBoard(9'b000000011, 9'b000011000));
        sbQ.push_back('{isMove: 1'b1, pos: 4'd5, lat: 2});
        issueReq(k);
        applyStimulus(18'd0);
        waitEvent(k, 40, seen, isMove, pos, lat);
        e = sbQ.pop_front();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL win_timeout got none want move"); end
        else begin
            checks++; if (pos !== e.pos) begin errors++; $display("[TB] FAIL win_pos got %0d want %0d", pos, e.pos); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL win_lat got %0d want %0d", lat, e.lat); end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset_mid_scan();
        int k, lat; bit seen, isMove; logic [3:0] pos; exp_t e;
        applyStimulus(18'd0);
        issueReq(k);
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.pc !== 1'b0 || bus.no_move !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_flags got busy=%b pc=%b nm=%b want 0 0 0", bus.busy, bus.pc, bus.no_move); end
        checks++; if (bus.computer_position !== 4'd0) begin errors++; $display("[TB] FAIL rst_async_pos got %0d want 0", bus.computer_position); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        sbQ.push_back('{isMove: 1'b1, pos: 4'd4, lat: 17});
        issueReq(k);
        waitEvent(k, 40, seen, isMove, pos, lat);
        e = sbQ.pop_front();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL rst_rerun_timeout got none want move"); end
        else begin
            checks++; if (pos !== e.pos) begin errors++; $display("[TB] FAIL rst_rerun_pos got %0d want %0d", pos, e.pos); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL rst_rerun_lat got %0d want %0d", lat, e.lat); end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_no_move();
        int k, lat; bit seen, isMove; logic [3:0] pos; exp_t e;
        applyStimulus(mkBoard(9'b110001101, 9'b001110010));
        sbQ.push_back('{isMove: 1'b0, pos: 4'd0, lat: 25});
        issueReq(k);
        waitEvent(k, 40, seen, isMove, pos, lat);
        e = sbQ.pop_front();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL nomove_timeout got none want no_move"); end
        else begin
            checks++; if (isMove !== e.isMove) begin errors++; $display("[TB] FAIL nomove_kind got pc=%b want pc=%b", isMove, e.isMove); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL nomove_lat got %0d want %0d", lat, e.lat); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL nomove_busy got %b want 0", bus.busy); end
            @(negedge clock);
            checks++; if (bus.no_move !== 1'b0 || bus.pc !== 1'b0) begin errors++; $display("[TB] FAIL nomove_pulse got nm=%b pc=%b want 0 0", bus.no_move, bus.pc); end
        end
    endtask

    task automatic test_game_over();
        int k, lat; bit seen, isMove; logic [3:0] pos;
        applyStimulus(18'd0);
        issueReq(k);
        repeat (5) @(posedge clock);
        #1 bus.game_over = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL gameover_abort got busy=%b want 0", bus.busy); end
        waitEvent(k, 30, seen, isMove, pos, lat);
        checks++; if (seen) begin errors++; $display("[TB] FAIL gameover_quiet got event pc=%b want none", isMove); end
        issueReq(k);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL gameover_req got busy=%b want 0", bus.busy); end
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL gameover_req2 got busy=%b want 0", bus.busy); end
        bus.game_over = 1'b0;
    endtask

    task automatic test_occupied_11();
        int k, lat; bit seen, isMove; logic [3:0] pos; exp_t e;
        applyStimulus(18'h00300);
        sbQ.push_back('{isMove: 1'b1, pos: 4'd0, lat: 18});
        issueReq(k);
        waitEvent(k, 40, seen, isMove, pos, lat);
        e = sbQ.pop_front();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL cell11_timeout got none want move"); end
        else begin
            checks++; if (pos !== e.pos) begin errors++; $display("[TB] FAIL cell11_pos got %0d want %0d", pos, e.pos); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL cell11_lat got %0d want %0d", lat, e.lat); end
        end
        repeat (4) @(negedge clock);
    endtask

    initial begin
        bus.req = 1'b0;
        bus.game_over = 1'b0;
        applyStimulus(18'd0);
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        test_center();
        test_block_and_drop();
        test_win_priority();
        test_reset_mid_scan();
        test_no_move();
        test_game_over();
        test_occupied_11();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
